// File: rtl/store_sequence_checker.sv
// Monitor for the core's data-memory write port. It compares the observed stores, in order,
// against a programmable table and holds a pass/fail/timeout verdict until the next start.
module store_sequence_checker #(
   parameter int XLEN    = 32,
   parameter int NUM_EXP = 4,
   parameter int TIMEOUT = 10000,
   parameter int STRICT  = 1,
   localparam int IW = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
   localparam int CW = $clog2(NUM_EXP) + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cfg_we,
   input  logic [IW-1:0]   cfg_idx,
   input  logic [XLEN-1:0] cfg_addr,
   input  logic [XLEN-1:0] cfg_data,
   input  logic [CW-1:0]   cfg_len,
   input  logic            ign_en,
   input  logic [XLEN-1:0] ign_lo,
   input  logic [XLEN-1:0] ign_hi,
   input  logic            start,
   input  logic            MemWrite,
   input  logic [XLEN-1:0] DataAdr,
   input  logic [XLEN-1:0] WriteData,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic            fail,
   output logic            timeout,
   output logic [CW-1:0]   match_cnt,
   output logic [XLEN-1:0] fail_addr,
   output logic [XLEN-1:0] fail_data,
   output logic [31:0]     cycle_cnt
);

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] data;
   } exp_t;

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TMO} state_t;

   state_t          r_state, w_state_nxt;
   exp_t            r_tab [NUM_EXP];
   logic [CW-1:0]   r_len;
   logic [CW-1:0]   r_match_cnt;
   logic [XLEN-1:0] r_fail_addr;
   logic [XLEN-1:0] r_fail_data;
   logic [31:0]     r_cycle_cnt;

   logic            w_clr, w_inc, w_cap;
   logic            w_ign, w_eq, w_hit, w_miss, w_last, w_tmo;
   logic [IW-1:0]   w_idx;
   exp_t            w_cur;
   logic [CW-1:0]   w_match_nxt;
   logic [CW-1:0]   w_len_norm;
   logic            w_idx_ok;

   assign w_idx       = r_match_cnt[IW-1:0];
   assign w_cur       = r_tab[w_idx];
   assign w_ign       = ign_en && (DataAdr >= ign_lo) && (DataAdr <= ign_hi);
   assign w_eq        = (DataAdr == w_cur.addr) && (WriteData == w_cur.data);
   assign w_hit       = MemWrite && !w_ign && w_eq;
   assign w_miss      = MemWrite && !w_ign && !w_eq;
   assign w_match_nxt = r_match_cnt + 1'b1;
   assign w_last      = (w_match_nxt == r_len);
   assign w_tmo       = (r_cycle_cnt == 32'(TIMEOUT - 1));
   // Zero or oversized lengths fall back to checking the whole table
   assign w_len_norm  = ((cfg_len == '0) || (32'(cfg_len) > NUM_EXP)) ? CW'(NUM_EXP) : cfg_len;
   assign w_idx_ok    = (32'(cfg_idx) < NUM_EXP);

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // A store on the final cycle is resolved before the timeout is considered
   always_comb begin
      w_state_nxt = r_state;
      w_clr       = 1'b0;
      w_inc       = 1'b0;
      w_cap       = 1'b0;
      case (r_state)
         S_RUN: begin
            if (w_hit) begin
               w_inc = 1'b1;
               if (w_last) w_state_nxt = S_PASS;
               else if (w_tmo) w_state_nxt = S_TMO;
            end else if (w_miss && (STRICT != 0)) begin
               w_cap       = 1'b1;
               w_state_nxt = S_FAIL;
            end else if (w_tmo) begin
               w_state_nxt = S_TMO;
            end
         end
         default: begin
            if (start) begin
               w_clr       = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_len       <= '0;
         r_match_cnt <= '0;
         r_fail_addr <= '0;
         r_fail_data <= '0;
         r_cycle_cnt <= '0;
      end else if (w_clr) begin
         r_len       <= w_len_norm;
         r_match_cnt <= '0;
         r_fail_addr <= '0;
         r_fail_data <= '0;
         r_cycle_cnt <= '0;
      end else begin
         if (w_inc) r_match_cnt <= w_match_nxt;
         if (w_cap) begin
            r_fail_addr <= DataAdr;
            r_fail_data <= WriteData;
         end
         // Frozen on the verdict edge so a timeout reads back TIMEOUT-1
         if ((r_state == S_RUN) && (w_state_nxt == S_RUN) && (r_cycle_cnt != '1))
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
   end

   // Table survives reset so a run can be repeated without reprogramming
   always_ff @(posedge clk) begin
      if (!reset && cfg_we && (r_state != S_RUN) && w_idx_ok)
         r_tab[cfg_idx] <= '{addr: cfg_addr, data: cfg_data};
   end

   assign busy      = (r_state == S_RUN);
   assign pass      = (r_state == S_PASS);
   assign fail      = (r_state == S_FAIL);
   assign timeout   = (r_state == S_TMO);
   assign done      = pass || fail || timeout;
   assign match_cnt = r_match_cnt;
   assign fail_addr = r_fail_addr;
   assign fail_data = r_fail_data;
   assign cycle_cnt = r_cycle_cnt;

endmodule

// File: doc/store_sequence_checker.md
Name: store_sequence_checker

Overview:
- Synthesizable self-checking monitor for the rv32i core's data-memory write port.
- Supersedes hard-coded pass/fail logic: checks an ordered, programmable sequence of up to NUM_EXP expected stores, with an ignore-address window and a cycle timeout.
- Result is held until the next start.
- Sits beside the core in simulation and FPGA bring-up; taps WriteData, DataAdr and MemWrite.

Parameters:
XLEN, 32, width of address and data.
NUM_EXP, 4, depth of the expected-store table (1..16).
TIMEOUT, 10000, cycles after start before timeout (>=1).
STRICT, 1, 1: any non-ignored store that mismatches the current entry fails; 0: mismatching stores are skipped.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high.
cfg_we  in  1  write one expected-table entry.
cfg_idx  in  $clog2(NUM_EXP)  entry index.
cfg_addr  in  XLEN  expected DataAdr.
cfg_data  in  XLEN  expected WriteData.
cfg_len  in  $clog2(NUM_EXP)+1  number of entries to check (1..NUM_EXP).
ign_en  in  1  enable the ignore window.
ign_lo  in  XLEN  ignore-window low address, inclusive.
ign_hi  in  XLEN  ignore-window high address, inclusive.
start  in  1  one-cycle pulse: begin checking.
MemWrite  in  1  core store strobe.
DataAdr  in  XLEN  core store address.
WriteData  in  XLEN  core store data.
busy  out  1  checking in progress.
done  out  1  result valid; sticky.
pass  out  1  all entries matched.
fail  out  1  mismatch detected.
timeout  out  1  TIMEOUT elapsed before completion.
match_cnt  out  $clog2(NUM_EXP)+1  entries matched so far.
fail_addr  out  XLEN  DataAdr of the failing store.
fail_data  out  XLEN  WriteData of the failing store.
cycle_cnt  out  32  cycles since start, saturating.

Behaviour:
- Reset:
  - Clock is clk; reset is synchronous, active-high.
  - All outputs 0.
  - State IDLE; table contents are not cleared.
- States:
  - IDLE: cfg_we writes table[cfg_idx] on the clock edge. start -> RUN, which clears match_cnt, cycle_cnt and the fail_* registers. cfg_len is latched at start.
  - RUN: busy=1. cfg_we is ignored.
  - PASS, FAIL, TIMEOUT: done=1 plus the matching flag. All terminal states are sticky. start -> RUN (re-arm); cfg_we is allowed.
- Store classification in RUN:
  - Each cycle with MemWrite=1 is one store, sampled at the rising edge; flags update the same edge, so latency is 1 cycle from the store to the flag.
  - ignored: ign_en=1 and ign_lo<=DataAdr<=ign_hi (unsigned). No effect.
  - match: DataAdr==table[match_cnt].addr and WriteData==table[match_cnt].data. match_cnt increments. If the new match_cnt == latched len -> PASS.
  - mismatch, STRICT=1: -> FAIL; capture DataAdr and WriteData into fail_addr and fail_data; match_cnt holds.
  - mismatch, STRICT=0: skipped, no effect.
- Timeout:
  - cycle_cnt increments every RUN cycle and saturates at 2^32-1.
  - When cycle_cnt reaches TIMEOUT-1 and no pass/fail occurs that edge -> TIMEOUT.
  - A store on the final cycle is evaluated first, so pass/fail wins over timeout.
- Simultaneous events:
  - start while in RUN is ignored.
  - reset overrides everything, including mid-run; the result is lost.
  - start and a store on the same edge in IDLE: the store is not checked.
- Degenerate length: cfg_len=0 or >NUM_EXP is treated as NUM_EXP.
- Exactly one of pass/fail/timeout is 1 when done=1; all three are 0 otherwise.

Test Plan:
1. Defaults, table[0]=(100,25), cfg_len=1, ign_en=1, ign 96..96; start; stores (96,7), (96,9), (100,25) -> stores at 96 ignored; pass=1, done=1 one cycle after the (100,25) store; match_cnt=1.
2. Same config; store (104,25) -> fail=1, fail_addr=104, fail_data=25, match_cnt=0. Then start and store (100,25) -> pass=1; fail and fail_* cleared.
3. cfg_len=3, table (0,1),(4,2),(8,3); stores (0,1),(4,2),(8,4) -> fail at the third store, match_cnt=2, fail_data=4.
4. STRICT=0, table (8,3), cfg_len=1; stores (12,5) then (8,3) -> (12,5) skipped; pass=1.
5. TIMEOUT=20; start with no stores -> timeout=1 exactly 20 cycles after start, cycle_cnt=19. Second run with the matching store on cycle 19 -> pass=1, timeout=0.
6. Assert reset for 1 cycle mid-RUN with match_cnt=1 -> next cycle all outputs 0, state IDLE. Table still holds its entries: start plus the correct stores -> pass=1.
